uart_frame_builder: RTL and testbench
=====================================

# uart_frame_builder

Host-side frame packetizer that produces the byte stream consumed by the UART controller's receive path. Payload bytes are buffered locally; on a send request the block emits one command byte {sel[1:0], length[5:0]} followed by exactly `length` payload bytes. Each byte is handed to a `UART_TX` instance through its DV/active/done handshake. Framing is therefore always consistent with the controller's command/length/data parser.

## Interface
- `DEPTH`, 64: buffer entries. Usable payload is capped at 63 by the 6-bit length field.
- `ADDR_W`, 6: buffer pointer width (log2 `DEPTH`).

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, synchronous, active-high.
- `i_wr_en` in 1: push `i_wr_byte` into the payload buffer.
- `i_wr_byte` in 8: payload byte.
- `o_full` in/out out 1: buffer holds 63 bytes, or a frame is in progress. Writes are dropped while high.
- `o_count` out 6: number of payload bytes currently buffered.
- `i_send` in 1: single-cycle request to transmit the buffered frame.
- `i_sel` in 2: destination select, sampled with `i_send`. Becomes header bits [7:6].
- `o_busy` out 1: a frame is in progress.
- `o_frame_done` out 1: one-cycle pulse after the last payload byte completes.
- `o_tx_dv` out 1: one-cycle start pulse to `UART_TX` `i_TX_DV`.
- `o_tx_byte` out 8: byte to `UART_TX` `i_TX_Byte`. Held stable from the `o_tx_dv` pulse until the matching `i_tx_done`.
- `i_tx_active` in 1: from `UART_TX` `o_TX_Active`.
- `i_tx_done` in 1: from `UART_TX` `o_TX_Done`.

## Operation
- Buffer:
  - Register array, write pointer `wr_ptr`, read pointer `rd_ptr`, 6-bit `o_count`.
  - In IDLE with `o_count < 63`, `i_wr_en` stores the byte at `wr_ptr`, then increments `wr_ptr` and `o_count`.
  - There is no wrap-around in use. Pointers return to 0 at the end of every frame and on reset.
- States: IDLE, HDR, HDR_WAIT, DATA, DATA_WAIT, DONE.
- IDLE:
  - `i_send` with `o_count != 0` latches `len = o_count` and `sel = i_sel`, then goes to HDR.
  - `i_send` with `o_count == 0` is ignored. A zero-length frame is never emitted, because the controller would hang on it.
- HDR: when `i_tx_active == 0`, pulse `o_tx_dv` with `o_tx_byte = {sel, len}` and go to HDR_WAIT. Otherwise stay.
- HDR_WAIT: on `i_tx_done`, set `rd_ptr = 0` and go to DATA.
- DATA: when `i_tx_active == 0`, pulse `o_tx_dv` with `o_tx_byte = buf[rd_ptr]`, increment `rd_ptr`, and go to DATA_WAIT.
- DATA_WAIT: on `i_tx_done`, go to DONE if `rd_ptr == len`, else to DATA.
- DONE:
  - Pulse `o_frame_done` and clear `wr_ptr`, `rd_ptr` and `o_count`.
  - Return to IDLE.
- `i_sel` values 2'b10 and 2'b11 are transmitted unchanged. Discarding them is the controller's decision.
- Simultaneous events in IDLE:
  - `i_send` together with `i_wr_en`: send wins, the write is dropped, and `len` excludes that byte.
  - `i_send` while `o_busy`: ignored.
  - `i_wr_en` while `o_full`: ignored, with no change to `o_count`.
- Reset mid-frame:
  - State returns to IDLE, the buffer empties, and `o_tx_dv` goes to 0 with no `o_frame_done`.
  - A byte already started in `UART_TX` finishes on the line. Downstream resynchronisation is out of scope.

## Timing
- Reset values: `o_full` 0, `o_count` 0, `o_busy` 0, `o_frame_done` 0, `o_tx_dv` 0, `o_tx_byte` 8'h00, state IDLE.
- All outputs are registered.
- `i_send` accepted at cycle t:
  - `o_busy` and `o_full` go high at t+1.
  - The header `o_tx_dv` pulse is issued at t+2 if `i_tx_active` was low at t+1.
- `i_tx_done` of byte k at cycle d: the `o_tx_dv` pulse for byte k+1 comes at d+2 at the earliest. Extra wait cycles are inserted while `i_tx_active` is high.
- `i_tx_done` of the last payload byte at cycle d:
  - `o_frame_done` is high at d+2.
  - `o_busy` and `o_full` are low and `o_count` is 0 at d+3.
- `o_tx_dv` is never high for two consecutive cycles.
- Exactly `len + 1` pulses are issued per frame.

## Test plan
- Write 0x11, 0x22, 0x33, then send with `i_sel=01`. Required: bytes 0x43, 0x11, 0x22, 0x33 in order, then one `o_frame_done` pulse and `o_count` back to 0.
- Send with an empty buffer. Required: no `o_tx_dv`, `o_busy` stays 0.
- Write 70 bytes (0x00 to 0x45). Required: `o_full` high at count 63, bytes 64 to 70 dropped. Send with `i_sel=00`: header 0x3F, then payload 0x00 to 0x3E.
- Hold `i_tx_active` high for 50 cycles after the header's `i_tx_done`. Required: no `o_tx_dv` until `i_tx_active` falls, then the next byte is issued.
- Assert `i_send` and `i_wr_en` together with 2 bytes buffered. Required: header length 2 and the third byte is not sent. Also, `i_wr_en` during the frame leaves `o_count` unchanged.
- Assert `rst` during DATA_WAIT of a 5-byte frame. Required: all outputs return to reset values the next cycle, no `o_frame_done`, and a following 1-byte frame sends a correct header and byte.

Source files
------------

// File: rtl/uart_frame_builder.sv
// Buffers payload bytes and, on request, emits {sel, length} followed by the
// payload to a UART_TX through its DV/active/done handshake.
module uart_frame_builder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_byte,
  output logic       o_full,
  output logic [5:0] o_count,
  input  logic       i_send,
  input  logic [1:0] i_sel,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_active,
  input  logic       i_tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    HDR_WAIT,
    DATA,
    DATA_WAIT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [5:0]        count_d;
  logic [5:0]        len_q, len_d;
  logic [1:0]        sel_q, sel_d;
  logic              full_d, busy_d, done_d, dv_d;
  logic [7:0]        byte_d;
  logic              wr_fire;

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q] <= i_wr_byte;
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = o_count;
    len_d    = len_q;
    sel_d    = sel_q;
    byte_d   = o_tx_byte;
    dv_d     = 1'b0;
    done_d   = 1'b0;
    wr_fire  = 1'b0;

    case (state_q)
      IDLE: begin
        // busy stays high for the cycle after DONE, so a request there is dropped
        if (!o_busy) begin
          if (i_send && o_count != '0) begin
            len_d   = o_count;
            sel_d   = i_sel;
            state_d = HDR;
          end else if (i_wr_en && !o_full) begin
            wr_fire  = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            count_d  = o_count + 6'd1;
          end
        end
      end
      HDR: begin
        if (!i_tx_active) begin
          dv_d    = 1'b1;
          byte_d  = {sel_q, len_q};
          state_d = HDR_WAIT;
        end
      end
      HDR_WAIT: begin
        if (i_tx_done) begin
          rd_ptr_d = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (!i_tx_active) begin
          dv_d     = 1'b1;
          byte_d   = mem[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          state_d  = DATA_WAIT;
        end
      end
      DATA_WAIT: begin
        if (i_tx_done) state_d = (6'(rd_ptr_q) == len_q) ? DONE : DATA;
      end
      DONE: begin
        done_d   = 1'b1;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || (state_q == DONE);
    full_d = busy_d || (count_d == 6'd63);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      sel_q        <= '0;
      o_count      <= '0;
      o_full       <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_tx_dv      <= 1'b0;
      o_tx_byte    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      len_q        <= len_d;
      sel_q        <= sel_d;
      o_count      <= count_d;
      o_full       <= full_d;
      o_busy       <= busy_d;
      o_frame_done <= done_d;
      o_tx_dv      <= dv_d;
      o_tx_byte    <= byte_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_builder.sv
// Self-checking bench for uart_frame_builder: table-driven frames, hand-written
// corner sequences and randomized frames against a queue-based frame model.
module tb_uart_frame_builder;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_wr_en;
  logic [7:0] i_wr_byte;
  logic       o_full;
  logic [5:0] o_count;
  logic       i_send;
  logic [1:0] i_sel;
  logic       o_busy;
  logic       o_frame_done;
  logic       o_tx_dv;
  logic [7:0] o_tx_byte;
  logic       i_tx_active;
  logic       i_tx_done;

  uart_frame_builder #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .i_wr_en(i_wr_en), .i_wr_byte(i_wr_byte),
    .o_full(o_full), .o_count(o_count),
    .i_send(i_send), .i_sel(i_sel),
    .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte),
    .i_tx_active(i_tx_active), .i_tx_done(i_tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [7:0] first;
    logic [7:0] stride;
    logic [1:0] sel;
    int         lat;
    int         exp_count;
    logic [7:0] exp_hdr;
    bit         wr_with_send;
    bit         stall;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int step_n = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] model_buf[$];

  int uart_cnt = 0, uart_lat = 1, force_cnt = 0;
  bit stall_arm = 0;
  int release_step = -1, stall_dv_step = -1, stall_err = 0;
  int last_done_step = 0, fd_step = 0, fd_count = 0;
  bit dv_prev = 0;
  int proto_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (step %0d)", name, act, exp, step_n);
    end
  endtask

  // One clock: observe outputs just after the edge, then drive the UART_TX model.
  task automatic step();
    @(posedge clk);
    #1;
    step_n++;
    if (o_tx_dv) begin
      if (dv_prev || uart_cnt > 0) proto_err++;
      if (force_cnt > 0) stall_err++;
      if (release_step >= 0 && stall_dv_step < 0) stall_dv_step = step_n;
      got_q.push_back(o_tx_byte);
    end
    dv_prev = o_tx_dv;
    if (o_frame_done) begin
      fd_count++;
      fd_step = step_n;
    end
    if (force_cnt > 0) begin
      force_cnt--;
      if (force_cnt == 0) release_step = step_n;
    end
    i_tx_done = 1'b0;
    if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) begin
        i_tx_done = 1'b1;
        last_done_step = step_n;
        if (stall_arm) begin
          stall_arm = 0;
          force_cnt = 50;
        end
      end
    end
    if (o_tx_dv) uart_cnt = uart_lat;
    i_tx_active = (uart_cnt > 0) || (force_cnt > 0);
  endtask

  task automatic write_bytes(input int n, input logic [7:0] first, input logic [7:0] stride,
                             input bit rnd);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom) : 8'(first + 8'(i) * stride);
      i_wr_en = 1'b1;
      i_wr_byte = b;
      if (model_buf.size() < 63) model_buf.push_back(b);
      step();
    end
    i_wr_en = 1'b0;
    step();
  endtask

  task automatic send_frame(input logic [1:0] sel, input int lat, input logic [7:0] exp_hdr,
                            input bit wr_with_send, input bit header_timing);
    int exp_len, budget, cnt_err;
    exp_len = model_buf.size();
    exp_q.delete();
    exp_q.push_back(exp_hdr);
    foreach (model_buf[i]) exp_q.push_back(model_buf[i]);
    model_buf.delete();
    got_q.delete();
    fd_count = 0;
    cnt_err = 0;
    uart_lat = lat;

    i_send = 1'b1;
    i_sel = sel;
    if (wr_with_send) begin
      i_wr_en = 1'b1;
      i_wr_byte = 8'h77;
    end
    step();
    i_send = 1'b0;
    i_wr_en = 1'b0;
    check("busy_after_send", o_busy, 1);
    check("full_after_send", o_full, 1);
    step();
    if (header_timing) begin
      check("hdr_dv_t+2", o_tx_dv, 1);
      check("hdr_byte", o_tx_byte, exp_hdr);
    end

    budget = 6000;
    while (fd_count == 0 && budget > 0) begin
      i_wr_en = 1'($urandom_range(0, 1));
      i_wr_byte = 8'($urandom);
      step();
      if (fd_count == 0 && o_count != 6'(exp_len)) cnt_err++;
      budget--;
    end
    i_wr_en = 1'b0;
    if (fd_count == 0) begin
      check("frame_done_timeout", 0, 1);
    end else begin
      check("frame_done_delay", fd_step - last_done_step, 2);
      check("busy_at_done", o_busy, 1);
      step();
      check("busy_cleared", o_busy, 0);
      check("full_cleared", o_full, 0);
      check("count_cleared", o_count, 0);
    end
    check("pulse_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("byte[%0d]", i), got_q[i], exp_q[i]);
    check("count_stable_in_frame", cnt_err, 0);
    for (int i = 0; i < 4; i++) step();
    check("single_done_pulse", fd_count, 1);
  endtask

  vec_t vecs[5];

  initial begin
    logic [7:0] hdr;
    int n, budget;
    logic [1:0] s;

    vecs[0] = '{3,  8'h11, 8'h11, 2'b01, 2, 3,  8'h43, 0, 0};
    vecs[1] = '{70, 8'h00, 8'h01, 2'b00, 1, 63, 8'h3F, 0, 0};
    vecs[2] = '{2,  8'h21, 8'h01, 2'b10, 3, 2,  8'h82, 1, 0};
    vecs[3] = '{4,  8'hA0, 8'h05, 2'b11, 2, 4,  8'hC4, 0, 1};
    vecs[4] = '{1,  8'hFF, 8'h00, 2'b01, 4, 1,  8'h41, 0, 0};

    rst = 1'b1;
    i_wr_en = 1'b0;
    i_wr_byte = '0;
    i_send = 1'b0;
    i_sel = '0;
    i_tx_active = 1'b0;
    i_tx_done = 1'b0;
    step();
    step();
    check("rst_full", o_full, 0);
    check("rst_count", o_count, 0);
    check("rst_busy", o_busy, 0);
    check("rst_frame_done", o_frame_done, 0);
    check("rst_tx_dv", o_tx_dv, 0);
    check("rst_tx_byte", o_tx_byte, 8'h00);
    rst = 1'b0;
    step();

    // Empty buffer: the request must be ignored.
    got_q.delete();
    i_send = 1'b1;
    i_sel = 2'b01;
    step();
    i_send = 1'b0;
    check("empty_send_busy", o_busy, 0);
    for (int i = 0; i < 10; i++) step();
    check("empty_send_busy_later", o_busy, 0);
    check("empty_send_no_dv", got_q.size(), 0);

    foreach (vecs[v]) begin
      write_bytes(vecs[v].n, vecs[v].first, vecs[v].stride, 0);
      check($sformatf("v%0d_count", v), o_count, vecs[v].exp_count);
      check($sformatf("v%0d_full", v), o_full, vecs[v].exp_count == 63);
      if (vecs[v].stall) begin
        stall_arm = 1;
        release_step = -1;
        stall_dv_step = -1;
        stall_err = 0;
      end
      send_frame(vecs[v].sel, vecs[v].lat, vecs[v].exp_hdr, vecs[v].wr_with_send, 1);
      if (vecs[v].stall) begin
        check("stall_no_dv_while_active", stall_err, 0);
        check("stall_release_to_dv", stall_dv_step - release_step, 1);
      end
    end

    // Reset while the second payload byte is in flight.
    write_bytes(5, 8'h60, 8'h01, 0);
    uart_lat = 6;
    got_q.delete();
    i_send = 1'b1;
    i_sel = 2'b01;
    step();
    i_send = 1'b0;
    budget = 500;
    while (got_q.size() < 3 && budget > 0) begin
      step();
      budget--;
    end
    check("reached_data_wait", got_q.size(), 3);
    rst = 1'b1;
    fd_count = 0;
    step();
    rst = 1'b0;
    model_buf.delete();
    check("midrst_full", o_full, 0);
    check("midrst_count", o_count, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_frame_done", o_frame_done, 0);
    check("midrst_tx_dv", o_tx_dv, 0);
    check("midrst_tx_byte", o_tx_byte, 8'h00);
    for (int i = 0; i < 20; i++) step();
    check("midrst_no_frame_done", fd_count, 0);
    write_bytes(1, 8'h5A, 8'h00, 0);
    check("post_rst_count", o_count, 1);
    send_frame(2'b01, 2, 8'h41, 0, 1);

    // Randomized frames checked against the queue model.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 63);
      s = 2'($urandom);
      write_bytes(n, 8'h00, 8'h00, 1);
      check($sformatf("rnd%0d_count", r), o_count, model_buf.size());
      hdr = {s, 6'(model_buf.size())};
      send_frame(s, $urandom_range(1, 5), hdr, 0, 1);
    end

    check("protocol_dv", proto_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
